gate_truth_checker: RTL
=======================

// Module: gate_truth_checker
// PURPOSE
//  Self-timed stimulus driver and response checker for an N_IN-input combinational gate.
//  It sits on the driving side of a gate under test: on START it sweeps every input
//  combination, holds each one long enough to settle, and samples the gate output.
//  It compares each sample with the expected FUNC result and reports the error count,
//  the first failing vector and PASS/DONE. It replaces ad-hoc initial-block stimulus
//  for the gate-level cells.
// PARAMETERS
//  N_IN    2  number of gate inputs; sweep length is 2**N_IN vectors (1..8)
//  SETTLE  2  extra cycles each vector is held before sampling (>=1)
//  FUNC    0  expected function: 0=AND 1=OR 2=XOR 3=NAND (reduction over STIM)
//  ERRW    8  width of the error counter
// PORTS
//  CLK       in   1      clock, rising edge
//  RST       in   1      asynchronous, active-high reset
//  START     in   1      begin a sweep; sampled only in IDLE or DONE
//  STIM      out  N_IN   input vector driven to the gate under test
//  DUT_OUT   in   1      gate-under-test output
//  BUSY      out  1      sweep in progress
//  DONE      out  1      sweep finished; held until the next START or RST
//  PASS      out  1      DONE and ERR_CNT==0
//  ERR_CNT   out  ERRW   mismatch count, saturating
//  FAIL_VLD  out  1      at least one mismatch captured
//  FAIL_VEC  out  N_IN   first failing STIM value
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE; takes effect immediately, even mid-sweep.
//  - All outputs are registered; no combinational path from DUT_OUT to any output.
//  - States: IDLE, HOLD, DONE.
//  - IDLE, START=1 at edge t: at t+1 go to HOLD with STIM=0 and BUSY=1.
//    ERR_CNT, FAIL_VLD, FAIL_VEC, DONE and PASS are all cleared at t+1.
//  - HOLD: each vector is held SETTLE+1 cycles. The settle counter goes 0..SETTLE.
//    At the edge where counter==SETTLE, DUT_OUT is sampled and compared with FUNC(STIM).
//  - Mismatch at a compare: ERR_CNT increments and saturates at all-ones.
//    If FAIL_VLD==0, FAIL_VEC<=STIM and FAIL_VLD<=1. Later mismatches leave FAIL_VEC unchanged.
//  - Same compare edge, STIM!=all-ones: STIM<=STIM+1, counter<=0, stay in HOLD.
//  - Same compare edge, STIM==all-ones: go to DONE, BUSY<=0, DONE<=1.
//    PASS<=(updated ERR_CNT==0), so a mismatch on the last vector counts.
//  - STIM holds its last value (all-ones) in DONE.
//  - Sweep length: 2**N_IN*(SETTLE+1) cycles from the first HOLD cycle to DONE rising.
//  - START while in HOLD: ignored, with no restart and no effect on counters.
//  - START while in DONE: same as from IDLE; results clear at the next edge.
//  - RST and START together: RST wins and the state stays IDLE.
//  - FUNC values outside 0..3 are treated as AND.
// TESTING
//  1. RST pulse mid-idle -> all outputs 0; START=0 for 20 cycles -> BUSY stays 0.
//  2. N_IN=2, SETTLE=2, FUNC=0, correct AND model -> STIM 00,01,10,11, each held 3 cycles.
//     DONE rises 12 cycles after the first HOLD cycle; PASS=1, ERR_CNT=0, FAIL_VLD=0.
//  3. Same setup, DUT_OUT stuck at 0 -> ERR_CNT=1, FAIL_VEC=2'b11, FAIL_VLD=1, PASS=0.
//  4. Same setup, DUT_OUT stuck at 1 -> ERR_CNT=3, FAIL_VEC=2'b00, PASS=0.
//  5. START pulses during HOLD are ignored. RST asserted at cycle 5 of a sweep ->
//     outputs 0 at once. A new START then gives a full clean sweep and PASS=1.
//  6. ERRW=1 with stuck-at-1 DUT -> ERR_CNT saturates at 1. START in DONE clears
//     the results and reruns the sweep.

Source files
------------

// File: rtl/gate_truth_checker.sv
// Self-timed exhaustive sweep of an N_IN-input gate: drives every input vector, samples the
// gate output after a settle window and counts mismatches against the expected function.
module gate_truth_checker #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned FUNC   = 0,
    parameter int unsigned ERRW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt,
    output logic            fail_vld,
    output logic [N_IN-1:0] fail_vec
);

    localparam int unsigned CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [1:0] {StIdle, StHold, StDone} state_e;

    state_e          state;
    logic [CW-1:0]   cnt;
    logic            expected;
    logic            mismatch;
    logic [ERRW-1:0] err_next;

    always_comb begin
        expected = &stim;
        case (FUNC)
            1:       expected = |stim;
            2:       expected = ^stim;
            3:       expected = ~&stim;
            default: expected = &stim;
        endcase
    end

    // Saturating increment so a flood of mismatches never wraps back to zero.
    always_comb begin
        mismatch = (dut_out != expected);
        err_next = err_cnt;
        if (mismatch && (err_cnt != {ERRW{1'b1}})) begin
            err_next = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            stim     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vld <= 1'b0;
            fail_vec <= '0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state    <= StHold;
                        cnt      <= '0;
                        stim     <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_cnt  <= '0;
                        fail_vld <= 1'b0;
                        fail_vec <= '0;
                    end
                end
                StHold: begin
                    if (cnt == CW'(SETTLE)) begin
                        err_cnt <= err_next;
                        if (mismatch && !fail_vld) begin
                            fail_vld <= 1'b1;
                            fail_vec <= stim;
                        end
                        if (stim != {N_IN{1'b1}}) begin
                            stim <= stim + 1'b1;
                            cnt  <= '0;
                        end else begin
                            // Last vector: pass uses the post-compare count.
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
